tape_decoder: RTL

- Tape-input receiver for the radio-86rk core. It converts the digitised cassette audio (1-bit comparator output) into bytes.
- Same audio path as the PWM sound output, opposite direction: decodes the phase-encoded (Manchester) tape stream instead of generating a 1-bit audio stream.
- Hunts for the RK-86 sync byte 0xE6 in either polarity, then delivers byte-aligned data with a one-cycle strobe to the tape-port logic (PPI port C input path).

---
 rtl/tape_pkg.sv | 14 +
 rtl/tape_in_filter.sv | 44 ++++
 rtl/tape_decoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// Shared types and constants for the cassette tape decoder.
package tape_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hE6;
  // Blanking window and timeout as fractions of a bit cell.
  localparam int BLANK_NUM = 3;
  localparam int BLANK_DEN = 4;
  localparam int TMO_MULT  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2
  } state_e;
endpackage

// File: rtl/tape_in_filter.sv
// Two-flop synchroniser plus glitch filter for the comparator input; flags accepted level changes.
module tape_in_filter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tape_i,
  output logic level_o,
  output logic edge_o
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  logic          sync1_q, sync2_q, level_q, edge_q;
  logic [FW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= tape_i;
      sync2_q <= sync1_q;
      edge_q  <= 1'b0;
      // Count consecutive disagreeing samples; any agreement restarts the count.
      if (sync2_q != level_q) begin
        if (cnt_q == FW'(FILTER_CYCLES - 1)) begin
          level_q <= ~level_q;
          edge_q  <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign edge_o  = edge_q;
endmodule

// File: rtl/tape_decoder.sv
// Manchester tape receiver: hunts for the 0xE6 sync byte in either polarity, then strobes out bytes.
module tape_decoder
  import tape_pkg::*;
#(
  parameter int CELL_CYCLES   = 40000,
  parameter int FILTER_CYCLES = 16,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       tape_in,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       synced,
  output logic       sync_err
);
  localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_NUM * CELL_CYCLES / BLANK_DEN);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TMO_MULT * CELL_CYCLES);

  logic level, edge_f;

  tape_in_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
    .clk    (clk),
    .reset_n(reset_n),
    .tape_i (tape_in),
    .level_o(level),
    .edge_o (edge_f)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       shift_q, shift_d, shifted;
  logic [2:0]       bcnt_q, bcnt_d;
  logic             pol_q, pol_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d, err_q, err_d;
  logic             mid_edge, timeout;

  assign shifted  = {shift_q[6:0], level};
  // Edges inside the blanking window are cell boundaries, not data.
  assign mid_edge = edge_f && (state_q != IDLE) && (timer_q >= BLANK);
  // A mid-cell edge landing on the last tick pre-empts the timeout.
  assign timeout  = (state_q != IDLE) && (timer_q == TMO - 1'b1) && !mid_edge;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    pol_d   = pol_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;

    if (state_q == IDLE || mid_edge) timer_d = '0;
    else if (timer_q < TMO)          timer_d = timer_q + 1'b1;

    case (state_q)
      IDLE: begin
        shift_d = '0;
        if (enable) state_d = HUNT;
      end
      HUNT: begin
        if (mid_edge) begin
          shift_d = shifted;
          if (shifted == SYNC_BYTE || shifted == ~SYNC_BYTE) begin
            pol_d   = (shifted != SYNC_BYTE);
            bcnt_d  = '0;
            state_d = DATA;
          end
        end else if (timeout) begin
          shift_d = '0;
        end
      end
      DATA: begin
        if (mid_edge) begin
          shift_d = shifted;
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            data_d = shifted ^ {8{pol_q}};
            dv_d   = 1'b1;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          shift_d = '0;
          state_d = HUNT;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte completing as enable falls is still delivered.
    if (!enable) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      pol_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      pol_q   <= pol_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign synced     = (state_q == DATA);
  assign sync_err   = err_q;
endmodule
